// File: rtl/core_sequencer_if.sv
// Host/core handshake bundle for core_sequencer: the host request, the core status
// inputs, and the sequencer's control and status outputs.
interface core_sequencer_if #(
  parameter int D = 9,
  parameter int W = 16
);
  logic         req;
  logic         halt;
  logic [D-1:0] prog_ctr;
  logic         core_rst;
  logic         core_en;
  logic         host_grant;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [W-1:0] cycle_cnt;

  // The host/testbench side drives the request and the core status.
  modport master (
    output req, halt, prog_ctr,
    input  core_rst, core_en, host_grant, busy, done, timeout, cycle_cnt
  );

  modport slave (
    input  req, halt, prog_ctr,
    output core_rst, core_en, host_grant, busy, done, timeout, cycle_cnt
  );
endinterface

// File: rtl/core_sequencer.sv
// Run sequencer for a small core: holds the core in reset, releases it for one run,
// and stops on halt, end PC or cycle limit. The host acknowledges via a four-phase handshake.
module core_sequencer #(
  parameter int D         = 9,
  parameter int HALT_PC   = 128,
  parameter int W         = 16,
  parameter int CYC_LIMIT = 65535,
  parameter int INIT_CYC  = 2
) (
  input  logic             clk,
  input  logic             reset,
  core_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0] CYC_LAST  = W'(CYC_LIMIT - 1);
  localparam logic [D-1:0] PC_END    = D'(HALT_PC);
  localparam logic [3:0]   INIT_LOAD = 4'(INIT_CYC - 1);

  logic [1:0]   state;
  logic [3:0]   init_cnt;
  logic [W-1:0] cyc;
  logic         timed_out;

  logic run_stop;
  logic run_limit;

  // A halt or end PC outranks the limit when both land in the same RUN cycle.
  assign run_stop  = bus.halt || (bus.prog_ctr == PC_END);
  assign run_limit = (cyc == CYC_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      init_cnt  <= '0;
      cyc       <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            state     <= S_INIT;
            init_cnt  <= INIT_LOAD;
            cyc       <= '0;
            timed_out <= 1'b0;
          end
        end
        S_INIT: begin
          if (init_cnt == 4'd0) begin
            state <= S_RUN;
          end else begin
            init_cnt <= init_cnt - 4'd1;
          end
        end
        S_RUN: begin
          // The exit cycle is counted too, so a limit exit reports exactly CYC_LIMIT.
          cyc <= cyc + W'(1);
          if (run_stop) begin
            state <= S_DONE;
          end else if (run_limit) begin
            state     <= S_DONE;
            timed_out <= 1'b1;
          end
        end
        S_DONE: begin
          // Leaving only on req low makes a held-high req unable to retrigger a run.
          if (!bus.req) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Control outputs are pure decodes of the registered state.
  assign bus.core_rst   = (state == S_IDLE) || (state == S_INIT);
  assign bus.core_en    = (state == S_RUN);
  assign bus.host_grant = (state == S_IDLE) || (state == S_DONE);
  assign bus.busy       = (state == S_INIT) || (state == S_RUN);
  assign bus.done       = (state == S_DONE);
  assign bus.timeout    = timed_out;
  assign bus.cycle_cnt  = cyc;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: the driver pushes each run's expected cycle count and
// timeout flag into a scoreboard queue, and a monitor checks them when done rises.
module tb_core_sequencer;

  localparam int D         = 9;
  localparam int W         = 16;
  localparam int CYC_LIMIT = 10;
  localparam int INIT_CYC  = 2;

  // {core_rst, core_en, host_grant, busy, done}
  localparam logic [4:0] O_IDLE = 5'b10100;
  localparam logic [4:0] O_INIT = 5'b10010;
  localparam logic [4:0] O_RUN  = 5'b01010;
  localparam logic [4:0] O_DONE = 5'b00101;

  typedef struct {
    logic [W-1:0] cnt;
    logic         to;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic prev_done = 1'b0;

  core_sequencer_if #(.D(D), .W(W)) bus ();

  core_sequencer #(
    .D(D), .HALT_PC(128), .W(W), .CYC_LIMIT(CYC_LIMIT), .INIT_CYC(INIT_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.core_rst, bus.core_en, bus.host_grant, bus.busy, bus.done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int cnt, input logic to);
    exp_t e;
    e.cnt = W'(cnt);
    e.to  = to;
    exp_q.push_back(e);
  endtask

  // Raise req and walk through INIT; returns in the first RUN cycle (cycle_cnt == 0).
  task automatic start_run(input string tag);
    bus.req = 1'b1;
    tick();
    check({tag, "_init1"}, outs(), O_INIT);
    check({tag, "_init_clr"}, {bus.timeout, bus.cycle_cnt}, 0);
    tick();
    check({tag, "_init2"}, outs(), O_INIT);
    tick();
    check({tag, "_run"}, outs(), O_RUN);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (bus.done && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_cycle_cnt", 32'(bus.cycle_cnt), 32'(e.cnt));
        check("sb_timeout", 32'(bus.timeout), 32'(e.to));
      end
    end
    prev_done <= bus.done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset        = 1'b1;
    bus.req      = 1'b0;
    bus.halt     = 1'b0;
    bus.prog_ctr = '0;
    tick();
    tick();
    check("reset_outs", outs(), O_IDLE);
    check("reset_cnt", {bus.timeout, bus.cycle_cnt}, 0);
    reset = 1'b0;
    tick();
    check("idle_outs", outs(), O_IDLE);

    // Normal run: halt in the 5th RUN cycle.
    start_run("normal");
    repeat (4) tick();
    bus.halt = 1'b1;
    push_exp(5, 1'b0);
    tick();
    bus.halt = 1'b0;
    check("normal_done", outs(), O_DONE);
    bus.req = 1'b0;
    tick();
    check("normal_idle", outs(), O_IDLE);

    // End-PC exit; halt and end PC are held during IDLE/INIT and must be ignored there.
    bus.halt     = 1'b1;
    bus.prog_ctr = 9'd128;
    start_run("pcend");
    bus.halt     = 1'b0;
    bus.prog_ctr = 9'd5;
    repeat (2) tick();
    bus.prog_ctr = 9'd128;
    push_exp(3, 1'b0);
    tick();
    bus.prog_ctr = '0;
    check("pcend_core_en_drop", outs(), O_DONE);
    bus.req = 1'b0;
    tick();

    // Timeout, then req held high through DONE.
    start_run("tmo");
    push_exp(CYC_LIMIT, 1'b1);
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    check("tmo_run_len", n, CYC_LIMIT);
    repeat (3) tick();
    check("tmo_hold_done", outs(), O_DONE);
    check("tmo_hold_flag", {bus.timeout, bus.cycle_cnt}, {1'b1, 16'(CYC_LIMIT)});
    bus.req = 1'b0;
    tick();
    check("tmo_idle", outs(), O_IDLE);

    // Tie: halt on the limit cycle; start_run also checks timeout is cleared in INIT.
    start_run("tie");
    repeat (CYC_LIMIT - 1) tick();
    check("tie_at_last", 32'(bus.cycle_cnt), CYC_LIMIT - 1);
    bus.halt = 1'b1;
    push_exp(CYC_LIMIT, 1'b0);
    tick();
    bus.halt = 1'b0;
    check("tie_done", outs(), O_DONE);
    bus.req = 1'b0;
    tick();

    // req dropped during RUN: the run completes and DONE lasts one cycle.
    start_run("hs");
    bus.req = 1'b0;
    repeat (2) tick();
    check("hs_still_run", outs(), O_RUN);
    bus.halt = 1'b1;
    push_exp(3, 1'b0);
    tick();
    bus.halt = 1'b0;
    check("hs_done", outs(), O_DONE);
    tick();
    check("hs_idle", outs(), O_IDLE);

    // Reset mid-RUN with req held high, then restart.
    start_run("rst");
    repeat (3) tick();
    check("rst_pre_cnt", 32'(bus.cycle_cnt), 3);
    reset = 1'b1;
    tick();
    check("rst_outs", outs(), O_IDLE);
    check("rst_cnt", {bus.timeout, bus.cycle_cnt}, 0);
    tick();
    check("rst_req_ignored", outs(), O_IDLE);
    reset = 1'b0;
    tick();
    check("rst_restart", outs(), O_INIT);
    tick();
    tick();
    check("rst_run", outs(), O_RUN);
    bus.halt = 1'b1;
    push_exp(1, 1'b0);
    tick();
    bus.halt = 1'b0;
    bus.req  = 1'b0;
    tick();
    tick();
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
